// File: rtl/store_buffer_unit.sv
// Store execution unit and in-order store buffer.
// Stores wait here until ROB commit, then drain one per cycle to data memory.
module store_buffer_unit #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [104:0] rs2exe,
    output logic         full,
    input  logic         commit,
    input  logic         flush,
    output logic [37:0]  cdb,
    output logic         dmem_write_en,
    output logic [31:0]  dmem_write_addr,
    output logic [31:0]  dmem_write_data,
    output logic [2:0]   dmem_write_width
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    // [head,cptr) are COMMITTED, [cptr,tail) are PENDING, the rest FREE
    ptr_t head;
    ptr_t cptr;
    ptr_t tail;

    logic [31:0] addr_q  [DEPTH];
    logic [31:0] data_q  [DEPTH];
    logic [2:0]  width_q [DEPTH];

    logic [2:0]  in_width;
    logic [5:0]  in_dest;
    logic [31:0] in_opr1;
    logic [31:0] in_opr2;
    logic [31:0] in_offset;

    logic        accept;
    logic        do_commit;
    logic        do_drain;
    ptr_t        cptr_next;
    ptr_t        count;

    assign in_width  = rs2exe[104:102];
    assign in_dest   = rs2exe[101:96];
    assign in_opr1   = rs2exe[95:64];
    assign in_opr2   = rs2exe[63:32];
    assign in_offset = rs2exe[31:0];

    assign count     = tail - head;
    assign full      = (count == ptr_t'(DEPTH));
    assign accept    = enable && !full && !flush;
    assign do_commit = commit && (cptr != tail);
    assign do_drain  = (head != cptr);
    assign cptr_next = cptr + ptr_t'(do_commit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head             <= '0;
            cptr             <= '0;
            tail             <= '0;
            cdb              <= '0;
            dmem_write_en    <= 1'b0;
            dmem_write_addr  <= 32'hFFFF_FFFF;
            dmem_write_data  <= '0;
            dmem_write_width <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                width_q[i] <= '0;
            end
        end else begin
            cptr <= cptr_next;
            if (flush) begin
                tail <= cptr_next;
            end else if (accept) begin
                addr_q[tail[AW-1:0]]  <= in_opr1 + in_offset;
                data_q[tail[AW-1:0]]  <= in_opr2;
                width_q[tail[AW-1:0]] <= in_width;
                tail                  <= tail + ptr_t'(1);
            end

            cdb <= accept ? {in_dest, 32'b0} : 38'b0;

            if (do_drain) begin
                head             <= head + ptr_t'(1);
                dmem_write_en    <= 1'b1;
                dmem_write_addr  <= addr_q[head[AW-1:0]];
                dmem_write_data  <= data_q[head[AW-1:0]];
                dmem_write_width <= width_q[head[AW-1:0]];
            end else begin
                dmem_write_en    <= 1'b0;
                dmem_write_addr  <= 32'hFFFF_FFFF;
                dmem_write_data  <= '0;
                dmem_write_width <= '0;
            end
        end
    end

endmodule
